// File: rtl/nibble_serial_adder_pkg.sv
// Shared types and constants for the nibble-serial adder and its 4-bit slice.
package nibble_serial_adder_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // One full-adder cell: returns {carry_out, sum}.
    function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
        return {(x & y) | (ci & (x ^ y)), x ^ y ^ ci};
    endfunction

endpackage

// File: rtl/nibble_serial_adder_slice.sv
// Combinational 4-bit ripple-carry slice built from four full-adder cells.
// With OVERFLOW_FLAG_EN the carry into the MSB cell is exported as msb_cin.
module adder4_slice
    import nibble_serial_adder_pkg::*;
(
    input  logic [NIBBLE_W-1:0] x,
    input  logic [NIBBLE_W-1:0] y,
    input  logic                cin,
    output logic [NIBBLE_W-1:0] sum,
    output logic                cout
`ifdef OVERFLOW_FLAG_EN
    ,
    output logic                msb_cin
`endif
);

    logic [NIBBLE_W:0] carry;

    assign carry[0] = cin;

    for (genvar i = 0; i < NIBBLE_W; i++) begin : g_fa
        assign {carry[i+1], sum[i]} = full_add(x[i], y[i], carry[i]);
    end

    assign cout = carry[NIBBLE_W];

`ifdef OVERFLOW_FLAG_EN
    assign msb_cin = carry[NIBBLE_W-1];
`endif

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle W-bit adder: one nibble per clock through a single 4-bit slice,
// valid/ready on both sides. Optional signed overflow flag via OVERFLOW_FLAG_EN.
module nibble_serial_adder
    import nibble_serial_adder_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [NIBBLE_W*NIBBLES-1:0] a,
    input  logic [NIBBLE_W*NIBBLES-1:0] b,
    input  logic                    cin,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [NIBBLE_W*NIBBLES-1:0] sum,
    output logic                    cout
`ifdef OVERFLOW_FLAG_EN
    ,
    output logic                    ovf
`endif
);

    localparam int W     = NIBBLE_W * NIBBLES;
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    state_e             state_q;
    logic [IDX_W-1:0]   idx_q;
    logic               carry_q;
    logic [W-1:0]       a_q;
    logic [W-1:0]       b_q;
    logic [W-1:0]       sum_q;
    logic [W-1:0]       sum_d;
    logic               cout_q;
    logic               in_ready_q;
    logic               out_valid_q;

    logic [NIBBLE_W-1:0] slice_sum;
    logic                slice_cout;

`ifdef OVERFLOW_FLAG_EN
    logic ovf_q;
    logic slice_msb_cin;
`endif

    adder4_slice u_slice (
        .x    (a_q[NIBBLE_W*idx_q +: NIBBLE_W]),
        .y    (b_q[NIBBLE_W*idx_q +: NIBBLE_W]),
        .cin  (carry_q),
        .sum  (slice_sum),
        .cout (slice_cout)
`ifdef OVERFLOW_FLAG_EN
        ,
        .msb_cin (slice_msb_cin)
`endif
    );

    // NOTE: combinational blocks use blocking '=' and assign a default first,
    // so every path drives sum_d and no latch is inferred.
    always_comb begin
        sum_d = sum_q;
        sum_d[NIBBLE_W*idx_q +: NIBBLE_W] = slice_sum;
    end

    // NOTE: every register here, operand registers included, is cleared by the
    // asynchronous reset; sequential state is updated only with '<='.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
`ifdef OVERFLOW_FLAG_EN
            ovf_q       <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q        <= a;
                        b_q        <= b;
                        carry_q    <= cin;
                        idx_q      <= '0;
                        sum_q      <= '0;
                        cout_q     <= 1'b0;
                        in_ready_q <= 1'b0;
                        state_q    <= RUN;
`ifdef OVERFLOW_FLAG_EN
                        ovf_q      <= 1'b0;
`endif
                    end
                end
                RUN: begin
                    sum_q   <= sum_d;
                    carry_q <= slice_cout;
                    if (idx_q == LAST_IDX) begin
                        idx_q       <= '0;
                        cout_q      <= slice_cout;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
`ifdef OVERFLOW_FLAG_EN
                        ovf_q       <= slice_msb_cin ^ slice_cout;
`endif
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                DONE: begin
                    // in_valid is deliberately ignored here; it is taken in IDLE.
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
`ifdef OVERFLOW_FLAG_EN
    assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder (NIBBLES=4 and NIBBLES=1 instances)
// against a plain-arithmetic reference; ovf checks compile only with OVERFLOW_FLAG_EN.
module tb_nibble_serial_adder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        cin = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] sum;
    logic        cout;
`ifdef OVERFLOW_FLAG_EN
    logic        ovf;
`endif

    logic        in_valid1 = 1'b0;
    logic        in_ready1;
    logic [3:0]  a1 = '0;
    logic [3:0]  b1 = '0;
    logic        cin1 = 1'b0;
    logic        out_valid1;
    logic        out_ready1 = 1'b1;
    logic [3:0]  sum1;
    logic        cout1;
`ifdef OVERFLOW_FLAG_EN
    logic        ovf1;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    nibble_serial_adder #(.NIBBLES(4)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
`ifdef OVERFLOW_FLAG_EN
        ,
        .ovf       (ovf)
`endif
    );

    nibble_serial_adder #(.NIBBLES(1)) u_dut1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid1),
        .in_ready  (in_ready1),
        .a         (a1),
        .b         (b1),
        .cin       (cin1),
        .out_valid (out_valid1),
        .out_ready (out_ready1),
        .sum       (sum1),
        .cout      (cout1)
`ifdef OVERFLOW_FLAG_EN
        ,
        .ovf       (ovf1)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Presents operands at a falling edge and returns just after the accepting edge.
    task automatic start(input logic [15:0] ta, input logic [15:0] tb_, input logic tc);
        @(negedge clk);
        check("in_ready_idle", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        a = ta;
        b = tb_;
        cin = tc;
        @(posedge clk);
    endtask

    // Counts edges from the accepting edge (counted as 1) until out_valid is seen.
    task automatic wait_valid(output int edges);
        edges = 1;
        @(negedge clk);
        in_valid = 1'b0;
        check("sum_cleared", 32'(sum), 32'd0);
        check("in_ready_run", 32'(in_ready), 32'd0);
        while (!out_valid && edges < 64) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
    endtask

    // Holds out_ready low for 'stall' cycles, then completes the handshake.
    task automatic drain(input int stall, input logic [15:0] exp_sum, input logic exp_cout);
        for (int k = 0; k < stall; k++) begin
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_sum", 32'({cout, sum}), 32'({exp_cout, exp_sum}));
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("valid_drop", 32'(out_valid), 32'd0);
        check("ready_back", 32'(in_ready), 32'd1);
    endtask

    task automatic run_one(input logic [15:0] ta, input logic [15:0] tb_, input logic tc, input int stall);
        logic [16:0] ref_sum;
        int          edges;
        ref_sum = 17'(ta) + 17'(tb_) + 17'(tc);
        start(ta, tb_, tc);
        wait_valid(edges);
        check("latency", 32'(edges), 32'd5);
        check("result", 32'({cout, sum}), 32'(ref_sum));
`ifdef OVERFLOW_FLAG_EN
        check("ovf", 32'(ovf), 32'((ta[15] == tb_[15]) && (ref_sum[15] != ta[15])));
`endif
        drain(stall, ref_sum[15:0], ref_sum[16]);
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] dir_a [5] = '{16'h1234, 16'hFFFF, 16'hFFFF, 16'h7FFF, 16'h8000};
        logic [15:0] dir_b [5] = '{16'h4321, 16'h0001, 16'hFFFF, 16'h0001, 16'h8000};
        logic        dir_c [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        int          edges;
        logic        saw_valid;

        #23;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_sum", 32'({cout, sum}), 32'd0);
        check("rst_n1_state", 32'({in_ready1, out_valid1, cout1, sum1}), 32'h40);
`ifdef OVERFLOW_FLAG_EN
        check("rst_ovf", 32'(ovf), 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 5; i++) run_one(dir_a[i], dir_b[i], dir_c[i], 0);

        // Backpressure with a competing operand set held during DONE.
        start(16'h1111, 16'h2222, 1'b0);
        wait_valid(edges);
        in_valid = 1'b1;
        a = 16'hAAAA;
        b = 16'h5555;
        for (int k = 0; k < 5; k++) begin
            check("bp_sum", 32'({cout, sum}), 32'h3333);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("bp_not_taken", 32'(in_ready), 32'd1);
        @(posedge clk);
        wait_valid(edges);
        check("bp_latency", 32'(edges), 32'd5);
        check("bp_result", 32'({cout, sum}), 32'hFFFF);
        drain(1, 16'hFFFF, 1'b0);

        // Reset pulse during the second RUN cycle.
        start(16'h1234, 16'h1111, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_sum", 32'(sum), 32'd0);
        #1 rst = 1'b0;
        saw_valid = 1'b0;
        repeat (10) begin
            @(negedge clk);
            saw_valid |= out_valid;
        end
        check("midrst_no_valid", 32'(saw_valid), 32'd0);
        run_one(16'h0001, 16'h0001, 1'b1, 0);

        repeat (40) begin
            run_one(16'($urandom), 16'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
        end

        // NIBBLES=1 exhaustive with cin=1.
        for (int x = 0; x < 16; x++) begin
            for (int y = 0; y < 16; y++) begin
                @(negedge clk);
                in_valid1 = 1'b1;
                a1 = 4'(x);
                b1 = 4'(y);
                cin1 = 1'b1;
                @(posedge clk);
                edges = 1;
                @(negedge clk);
                in_valid1 = 1'b0;
                while (!out_valid1 && edges < 16) begin
                    @(posedge clk);
                    edges++;
                    @(negedge clk);
                end
                check("n1_latency", 32'(edges), 32'd2);
                check("n1_result", 32'({cout1, sum1}), 32'(x + y + 1));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
